icache_upstream_txdat_buffer: RTL and testbench

ICACHE_UPSTREAM_TXDAT_BUFFER -- requirements
Module: icache_upstream_txdat_buffer

---
 rtl/icache_upstream_txdat_buffer.sv | 118 +++++++++++
 tb/tb_icache_upstream_txdat_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_upstream_txdat_buffer.sv
// Cacheline response buffer: queues 512-bit lines from the data array and
// returns each one to the fetch unit as two 256-bit beats.
module icache_upstream_txdat_buffer #(
  parameter int DEPTH                      = 4,
  parameter int AFULL_MARGIN               = 2,
  parameter int ICACHE_UPSTREAM_DATA_WIDTH = 512,
  parameter int ICACHE_REQ_TXNID_WIDTH     = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    upstream_txdat_vld,
  input  logic [ICACHE_UPSTREAM_DATA_WIDTH-1:0]   upstream_txdat_data,
  input  logic [ICACHE_REQ_TXNID_WIDTH-1:0]       upstream_txdat_txnid,
  output logic                                    txdat_afull,
  output logic                                    core_rsp_vld,
  input  logic                                    core_rsp_rdy,
  output logic [ICACHE_UPSTREAM_DATA_WIDTH/2-1:0] core_rsp_data,
  output logic [ICACHE_REQ_TXNID_WIDTH-1:0]       core_rsp_txnid,
  output logic                                    core_rsp_last,
  output logic                                    overflow_err,
  output logic [$clog2(DEPTH):0]                  occupancy
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int BEAT_W = ICACHE_UPSTREAM_DATA_WIDTH / 2;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t                                  state, state_next;
  logic [ICACHE_UPSTREAM_DATA_WIDTH-1:0]   data_mem  [DEPTH];
  logic [ICACHE_REQ_TXNID_WIDTH-1:0]       txnid_mem [DEPTH];
  logic [AW-1:0]                           wr_ptr, rd_ptr;
  logic [CW-1:0]                           count, count_next;
  logic [CW-1:0]                           free_next;
  logic                                    push, pop, full;

  assign full = (count == CW'(DEPTH));
  assign pop  = (state == BEAT1) && core_rsp_rdy;
  // A full buffer still accepts a line when the final beat leaves in the same cycle.
  assign push = upstream_txdat_vld && (!full || pop);

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  assign free_next = CW'(DEPTH) - count_next;
  assign occupancy = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
      txdat_afull  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count       <= count_next;
      txdat_afull <= (free_next <= CW'(AFULL_MARGIN));
      if (upstream_txdat_vld && full && !pop)
        overflow_err <= 1'b1;
    end
  end

  // Line storage is not reset; count and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr]  <= upstream_txdat_data;
      txnid_mem[wr_ptr] <= upstream_txdat_txnid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next     = state;
    core_rsp_vld   = 1'b0;
    core_rsp_data  = '0;
    core_rsp_txnid = '0;
    core_rsp_last  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0)
          state_next = BEAT0;
      end
      BEAT0: begin
        core_rsp_vld   = 1'b1;
        core_rsp_data  = data_mem[rd_ptr][BEAT_W-1:0];
        core_rsp_txnid = txnid_mem[rd_ptr];
        if (core_rsp_rdy)
          state_next = BEAT1;
      end
      BEAT1: begin
        core_rsp_vld   = 1'b1;
        core_rsp_data  = data_mem[rd_ptr][ICACHE_UPSTREAM_DATA_WIDTH-1:BEAT_W];
        core_rsp_txnid = txnid_mem[rd_ptr];
        core_rsp_last  = 1'b1;
        if (core_rsp_rdy)
          state_next = (count_next != '0) ? BEAT0 : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_upstream_txdat_buffer.sv
// Directed bench for icache_upstream_txdat_buffer: each task drives one
// scenario and compares outputs against hand-derived values.
module tb_icache_upstream_txdat_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         vld;
  logic [511:0] din;
  logic [7:0]   tid;
  logic         rdy;
  logic         txdat_afull;
  logic         core_rsp_vld;
  logic [255:0] core_rsp_data;
  logic [7:0]   core_rsp_txnid;
  logic         core_rsp_last;
  logic         overflow_err;
  logic [2:0]   occupancy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  icache_upstream_txdat_buffer #(
    .DEPTH(4),
    .AFULL_MARGIN(2),
    .ICACHE_UPSTREAM_DATA_WIDTH(512),
    .ICACHE_REQ_TXNID_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .upstream_txdat_vld(vld),
    .upstream_txdat_data(din),
    .upstream_txdat_txnid(tid),
    .txdat_afull(txdat_afull),
    .core_rsp_vld(core_rsp_vld),
    .core_rsp_rdy(rdy),
    .core_rsp_data(core_rsp_data),
    .core_rsp_txnid(core_rsp_txnid),
    .core_rsp_last(core_rsp_last),
    .overflow_err(overflow_err),
    .occupancy(occupancy)
  );

  function automatic logic [255:0] lo_of(input logic [7:0] id);
    return {8{24'hA0A0A0, id}};
  endfunction

  function automatic logic [255:0] hi_of(input logic [7:0] id);
    return {8{24'hB0B0B0, id}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = 1'b0; rdy = 1'b0; din = '0; tid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push_line(input logic [7:0] id);
    vld = 1'b1;
    tid = id;
    din = {hi_of(id), lo_of(id)};
    step();
    vld = 1'b0;
  endtask

  task automatic wait_vld(output bit ok);
    int n = 0;
    while (!core_rsp_vld && n < 6) begin
      step();
      n++;
    end
    ok = core_rsp_vld;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (core_rsp_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld got %b want 0", core_rsp_vld); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("[TB] FAIL reset_occ got %0d want 0", occupancy); end
    checks++; if (txdat_afull !== 1'b0) begin errors++; $display("[TB] FAIL reset_afull got %b want 0", txdat_afull); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf got %b want 0", overflow_err); end
    checks++; if (core_rsp_data !== 256'd0 || core_rsp_txnid !== 8'd0 || core_rsp_last !== 1'b0)
      begin errors++; $display("[TB] FAIL reset_outs got data=%h txnid=%h last=%b want zeros", core_rsp_data, core_rsp_txnid, core_rsp_last); end
  endtask

  task automatic test_single_line();
    bit ok;
    do_reset();
    rdy = 1'b1;
    push_line(8'd5);
    checks++; if (occupancy !== 3'd1) begin errors++; $display("[TB] FAIL single_occ1 got %0d want 1", occupancy); end
    wait_vld(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL single_timeout got vld=0 want 1"); end
    checks++; if (core_rsp_data !== lo_of(8'd5) || core_rsp_last !== 1'b0 || core_rsp_txnid !== 8'd5)
      begin errors++; $display("[TB] FAIL single_beat0 got data=%h last=%b txnid=%h want data=%h last=0 txnid=05", core_rsp_data, core_rsp_last, core_rsp_txnid, lo_of(8'd5)); end
    step();
    checks++; if (core_rsp_vld !== 1'b1 || core_rsp_data !== hi_of(8'd5) || core_rsp_last !== 1'b1 || core_rsp_txnid !== 8'd5)
      begin errors++; $display("[TB] FAIL single_beat1 got vld=%b data=%h last=%b txnid=%h want vld=1 data=%h last=1 txnid=05", core_rsp_vld, core_rsp_data, core_rsp_last, core_rsp_txnid, hi_of(8'd5)); end
    step();
    checks++; if (core_rsp_vld !== 1'b0 || occupancy !== 3'd0)
      begin errors++; $display("[TB] FAIL single_idle got vld=%b occ=%0d want vld=0 occ=0", core_rsp_vld, occupancy); end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    rdy = 1'b0;
    push_line(8'h20);
    checks++; if (txdat_afull !== 1'b0) begin errors++; $display("[TB] FAIL fill_afull1 got %b want 0", txdat_afull); end
    push_line(8'h21);
    checks++; if (txdat_afull !== 1'b1) begin errors++; $display("[TB] FAIL fill_afull2 got %b want 1", txdat_afull); end
    push_line(8'h22);
    push_line(8'h23);
    checks++; if (occupancy !== 3'd4 || overflow_err !== 1'b0)
      begin errors++; $display("[TB] FAIL fill_full got occ=%0d ovf=%b want occ=4 ovf=0", occupancy, overflow_err); end
    push_line(8'h24);
    checks++; if (occupancy !== 3'd4 || overflow_err !== 1'b1)
      begin errors++; $display("[TB] FAIL fill_drop got occ=%0d ovf=%b want occ=4 ovf=1", occupancy, overflow_err); end
    step();
    step();
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("[TB] FAIL fill_sticky got %b want 1", overflow_err); end
    rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (core_rsp_vld !== 1'b1 || core_rsp_txnid !== 8'(8'h20 + k) || core_rsp_data !== lo_of(8'(8'h20 + k)))
        begin errors++; $display("[TB] FAIL fill_drain got vld=%b txnid=%h want vld=1 txnid=%h", core_rsp_vld, core_rsp_txnid, 8'(8'h20 + k)); end
      step();
      step();
    end
    checks++; if (core_rsp_vld !== 1'b0 || occupancy !== 3'd0 || overflow_err !== 1'b1)
      begin errors++; $display("[TB] FAIL fill_end got vld=%b occ=%0d ovf=%b want vld=0 occ=0 ovf=1", core_rsp_vld, occupancy, overflow_err); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    rdy = 1'b0;
    for (int k = 0; k < 4; k++) push_line(8'(8'h10 + k));
    rdy = 1'b1;
    step();
    checks++; if (core_rsp_last !== 1'b1 || core_rsp_txnid !== 8'h10)
      begin errors++; $display("[TB] FAIL fpp_beat1 got last=%b txnid=%h want last=1 txnid=10", core_rsp_last, core_rsp_txnid); end
    push_line(8'h14);
    checks++; if (occupancy !== 3'd4 || overflow_err !== 1'b0)
      begin errors++; $display("[TB] FAIL fpp_occ got occ=%0d ovf=%b want occ=4 ovf=0", occupancy, overflow_err); end
    for (int k = 1; k <= 4; k++) begin
      checks++; if (core_rsp_vld !== 1'b1 || core_rsp_last !== 1'b0 || core_rsp_txnid !== 8'(8'h10 + k) || core_rsp_data !== lo_of(8'(8'h10 + k)))
        begin errors++; $display("[TB] FAIL fpp_b0 got vld=%b last=%b txnid=%h want vld=1 last=0 txnid=%h", core_rsp_vld, core_rsp_last, core_rsp_txnid, 8'(8'h10 + k)); end
      step();
      checks++; if (core_rsp_vld !== 1'b1 || core_rsp_last !== 1'b1 || core_rsp_txnid !== 8'(8'h10 + k) || core_rsp_data !== hi_of(8'(8'h10 + k)))
        begin errors++; $display("[TB] FAIL fpp_b1 got vld=%b last=%b txnid=%h want vld=1 last=1 txnid=%h", core_rsp_vld, core_rsp_last, core_rsp_txnid, 8'(8'h10 + k)); end
      step();
    end
    checks++; if (core_rsp_vld !== 1'b0 || occupancy !== 3'd0)
      begin errors++; $display("[TB] FAIL fpp_end got vld=%b occ=%0d want vld=0 occ=0", core_rsp_vld, occupancy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit pat [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int hs   = 0;
    int beat = 0;
    do_reset();
    rdy = 1'b0;
    push_line(8'h33);
    wait_vld(ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_timeout got vld=0 want 1"); end
    for (int i = 0; i < 5; i++) begin
      rdy = pat[i];
      checks++; if (core_rsp_vld !== 1'b1 || core_rsp_last !== (beat == 1) || core_rsp_txnid !== 8'h33 ||
                    core_rsp_data !== ((beat == 1) ? hi_of(8'h33) : lo_of(8'h33)))
        begin errors++; $display("[TB] FAIL bp_stable cycle %0d got vld=%b last=%b txnid=%h data=%h want beat %0d of txnid 33", i, core_rsp_vld, core_rsp_last, core_rsp_txnid, core_rsp_data, beat); end
      if (rdy && core_rsp_vld) begin hs++; beat++; end
      step();
    end
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (core_rsp_vld) hs++;
      step();
    end
    checks++; if (hs !== 2) begin errors++; $display("[TB] FAIL bp_handshakes got %0d want 2", hs); end
  endtask

  task automatic test_wrap();
    logic [7:0] ids [10];
    for (int k = 0; k < 10; k++) ids[k] = 8'($urandom_range(0, 255));
    do_reset();
    rdy = 1'b1;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          push_line(ids[k]);
          step();
        end
      end
      begin
        for (int k = 0; k < 10; k++) begin
          if (k == 0) begin
            bit ok;
            wait_vld(ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL wrap_timeout got vld=0 want 1"); end
          end
          checks++; if (core_rsp_vld !== 1'b1 || core_rsp_last !== 1'b0 || core_rsp_txnid !== ids[k])
            begin errors++; $display("[TB] FAIL wrap_b0 line %0d got vld=%b last=%b txnid=%h want vld=1 last=0 txnid=%h", k, core_rsp_vld, core_rsp_last, core_rsp_txnid, ids[k]); end
          step();
          checks++; if (core_rsp_vld !== 1'b1 || core_rsp_last !== 1'b1 || core_rsp_txnid !== ids[k] || core_rsp_data !== hi_of(ids[k]))
            begin errors++; $display("[TB] FAIL wrap_b1 line %0d got vld=%b last=%b txnid=%h want vld=1 last=1 txnid=%h", k, core_rsp_vld, core_rsp_last, core_rsp_txnid, ids[k]); end
          step();
        end
      end
    join
    checks++; if (core_rsp_vld !== 1'b0 || occupancy !== 3'd0 || overflow_err !== 1'b0)
      begin errors++; $display("[TB] FAIL wrap_end got vld=%b occ=%0d ovf=%b want vld=0 occ=0 ovf=0", core_rsp_vld, occupancy, overflow_err); end
  endtask

  task automatic test_reset_mid_line();
    do_reset();
    rdy = 1'b0;
    push_line(8'h41);
    push_line(8'h42);
    push_line(8'h43);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    checks++; if (core_rsp_last !== 1'b1 || txdat_afull !== 1'b1 || occupancy !== 3'd3)
      begin errors++; $display("[TB] FAIL rmid_pre got last=%b afull=%b occ=%0d want last=1 afull=1 occ=3", core_rsp_last, txdat_afull, occupancy); end
    rst = 1'b1;
    step();
    checks++; if (core_rsp_vld !== 1'b0 || occupancy !== 3'd0 || txdat_afull !== 1'b0)
      begin errors++; $display("[TB] FAIL rmid_post got vld=%b occ=%0d afull=%b want vld=0 occ=0 afull=0", core_rsp_vld, occupancy, txdat_afull); end
    rst = 1'b0;
    rdy = 1'b1;
    step();
    step();
    checks++; if (core_rsp_vld !== 1'b0) begin errors++; $display("[TB] FAIL rmid_discard got vld=%b want 0", core_rsp_vld); end
  endtask

  initial begin
    $display("[TB] starting");
    test_reset();
    test_single_line();
    test_fill_overflow();
    test_full_push_pop();
    test_backpressure();
    test_wrap();
    test_reset_mid_line();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
